// File: rtl/sd_data_serializer_if.sv
// Bus between sd_data_master (master side) and the DAT-line serializer (slave side).
// Carries FIFO strobes/data, the DAT[3:0] pins and the completion/CRC status.
interface sd_data_serializer_if #(
    parameter int BLKSIZE_W = 12
);
    logic                 start_write_i;
    logic                 start_read_i;
    logic [BLKSIZE_W-1:0] blksize_i;
    logic                 rd_o;
    logic [31:0]          data_in_i;
    logic                 we_o;
    logic [31:0]          data_out_o;
    logic                 dat_oe_o;
    logic [3:0]           dat_o;
    logic [3:0]           dat_i;
    logic                 xfr_complete_o;
    logic                 crc_ok_o;

    modport slave (
        input  start_write_i, start_read_i, blksize_i, data_in_i, dat_i,
        output rd_o, we_o, data_out_o, dat_oe_o, dat_o, xfr_complete_o, crc_ok_o
    );

    modport master (
        output start_write_i, start_read_i, blksize_i, data_in_i, dat_i,
        input  rd_o, we_o, data_out_o, dat_oe_o, dat_o, xfr_complete_o, crc_ok_o
    );
endinterface

// File: rtl/sd_data_serializer.sv
// Moves one data block between the FIFOs and the 4-bit SD DAT bus, with a
// CRC16-CCITT per DAT line; reports completion and CRC status to the master.
module sd_data_serializer #(
    parameter int BLKSIZE_W = 12
) (
    input  logic                 sd_clk,
    input  logic                 rst,
    sd_data_serializer_if.slave  bus
);
    localparam int CW = BLKSIZE_W + 1;

    typedef enum logic [3:0] {
        S_IDLE, S_WR_FETCH, S_WR_PRE, S_WR_START, S_WR_DATA, S_WR_CRC, S_WR_END,
        S_WR_STAT, S_WR_BUSY, S_RD_WAIT, S_RD_DATA, S_RD_CRC, S_RD_END
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  r_last;
    logic [3:0]     r_bit;
    logic [31:0]    r_shift;
    logic           r_rd_d;
    logic [1:0]     r_stat;
    logic           r_stat_go;
    logic           r_we;
    logic [31:0]    r_data_out;
    logic           r_crc_ok;
    logic [15:0]    r_crc    [4];
    logic [15:0]    r_rx_crc [4];

    logic           w_abort;
    logic           w_start;
    logic           w_cnt_last;
    logic           w_word_end;
    logic [3:0]     w_tx_nib;
    logic [3:0]     w_crc_bits;
    logic [3:0]     w_crc_msb;
    logic [3:0]     w_crc_match;
    logic [15:0]    w_crc_next [4];
    logic           w_rd;
    logic           w_oe;
    logic [3:0]     w_dat;

    assign w_abort    = bus.start_write_i & bus.start_read_i;
    assign w_start    = bus.start_write_i | bus.start_read_i;
    assign w_cnt_last = (r_cnt == r_last);
    assign w_word_end = (r_cnt[2:0] == 3'd7);

    // The word fetched by the previous rd_o is only valid this cycle, so its
    // first nibble bypasses the shift register to keep the stream gapless.
    assign w_tx_nib   = r_rd_d ? bus.data_in_i[31:28] : r_shift[31:28];
    assign w_crc_bits = (r_state == S_WR_DATA) ? w_tx_nib : bus.dat_i;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_line
            assign w_crc_next[gi]  = {r_crc[gi][14:0], 1'b0}
                                   ^ ((r_crc[gi][15] ^ w_crc_bits[gi]) ? 16'h1021 : 16'h0000);
            assign w_crc_msb[gi]   = r_crc[gi][15];
            assign w_crc_match[gi] = (r_rx_crc[gi] == r_crc[gi]);
        end
    endgenerate

    always_ff @(posedge sd_clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_rd         = 1'b0;
        w_oe         = 1'b0;
        w_dat        = 4'hF;
        case (r_state)
            S_IDLE: begin
                if (bus.start_write_i)     w_state_next = S_WR_FETCH;
                else if (bus.start_read_i) w_state_next = S_RD_WAIT;
            end
            S_WR_FETCH: begin
                w_rd         = 1'b1;
                w_state_next = S_WR_PRE;
            end
            S_WR_PRE: begin
                w_oe         = 1'b1;
                w_state_next = S_WR_START;
            end
            S_WR_START: begin
                w_oe         = 1'b1;
                w_dat        = 4'h0;
                w_state_next = S_WR_DATA;
            end
            S_WR_DATA: begin
                w_oe  = 1'b1;
                w_dat = w_tx_nib;
                w_rd  = w_word_end & ~w_cnt_last;
                if (w_cnt_last) w_state_next = S_WR_CRC;
            end
            S_WR_CRC: begin
                w_oe  = 1'b1;
                w_dat = w_crc_msb;
                if (r_bit == 4'd15) w_state_next = S_WR_END;
            end
            S_WR_END: begin
                w_oe         = 1'b1;
                w_state_next = S_WR_STAT;
            end
            S_WR_STAT: begin
                if (r_stat_go && r_bit == 4'd2) w_state_next = S_WR_BUSY;
            end
            S_WR_BUSY: begin
                if (bus.dat_i[0]) w_state_next = S_IDLE;
            end
            S_RD_WAIT: begin
                if (!bus.dat_i[0]) w_state_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                if (w_cnt_last) w_state_next = S_RD_CRC;
            end
            S_RD_CRC: begin
                if (r_bit == 4'd15) w_state_next = S_RD_END;
            end
            S_RD_END: begin
                w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_abort) begin
            w_state_next = S_IDLE;
            w_rd         = 1'b0;
        end
    end

    always_ff @(posedge sd_clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_last     <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_rd_d     <= 1'b0;
            r_stat     <= '0;
            r_stat_go  <= 1'b0;
            r_we       <= 1'b0;
            r_data_out <= '0;
            r_crc_ok   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_crc[i]    <= '0;
                r_rx_crc[i] <= '0;
            end
        end else begin
            r_we   <= 1'b0;
            r_rd_d <= w_rd;
            if (w_abort) begin
                r_crc_ok  <= 1'b0;
                r_stat_go <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_crc_ok  <= 1'b0;
                            r_last    <= {bus.blksize_i, 1'b0} - 1'b1;
                            r_cnt     <= '0;
                            r_bit     <= '0;
                            r_stat_go <= 1'b0;
                            for (int i = 0; i < 4; i++) r_crc[i] <= '0;
                        end
                    end
                    S_WR_PRE: r_shift <= bus.data_in_i;
                    S_WR_DATA: begin
                        r_shift <= r_rd_d ? {bus.data_in_i[27:0], 4'h0} : {r_shift[27:0], 4'h0};
                        r_cnt   <= r_cnt + 1'b1;
                        for (int i = 0; i < 4; i++) r_crc[i] <= w_crc_next[i];
                    end
                    S_WR_CRC: begin
                        r_bit <= r_bit + 4'd1;
                        for (int i = 0; i < 4; i++) r_crc[i] <= {r_crc[i][14:0], 1'b0};
                    end
                    S_WR_END: r_bit <= '0;
                    S_WR_STAT: begin
                        // Wait for the status start bit, then shift in three status bits.
                        if (!r_stat_go) begin
                            if (!bus.dat_i[0]) r_stat_go <= 1'b1;
                        end else begin
                            r_stat <= {r_stat[0], bus.dat_i[0]};
                            r_bit  <= r_bit + 4'd1;
                            if (r_bit == 4'd2)
                                r_crc_ok <= ({r_stat, bus.dat_i[0]} == 3'b010);
                        end
                    end
                    S_RD_DATA: begin
                        r_shift <= {r_shift[27:0], bus.dat_i};
                        r_cnt   <= r_cnt + 1'b1;
                        for (int i = 0; i < 4; i++) r_crc[i] <= w_crc_next[i];
                        if (w_word_end) begin
                            r_we       <= 1'b1;
                            r_data_out <= {r_shift[27:0], bus.dat_i};
                        end
                    end
                    S_RD_CRC: begin
                        r_bit <= r_bit + 4'd1;
                        for (int i = 0; i < 4; i++) r_rx_crc[i] <= {r_rx_crc[i][14:0], bus.dat_i[i]};
                    end
                    S_RD_END: r_crc_ok <= &w_crc_match;
                    default: ;
                endcase
            end
        end
    end

    assign bus.rd_o           = w_rd;
    assign bus.dat_oe_o       = w_oe;
    assign bus.dat_o          = w_dat;
    assign bus.we_o           = r_we;
    assign bus.data_out_o     = r_data_out;
    assign bus.xfr_complete_o = (r_state == S_IDLE);
    assign bus.crc_ok_o       = r_crc_ok;
endmodule

// File: tb/tb_sd_data_serializer.sv
// Randomised scoreboard bench for sd_data_serializer: a FIFO/card model drives
// the DUT while a negedge monitor compares DAT, FIFO writes and status.
module tb_sd_data_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sd_data_serializer_if #(.BLKSIZE_W(12)) bus();
    sd_data_serializer #(.BLKSIZE_W(12)) dut (.sd_clk(clk), .rst(rst_n), .bus(bus));

    typedef struct { logic ok; int rds; } done_t;

    logic [3:0]  q_dat[$];
    logic [31:0] q_we[$];
    done_t       q_done[$];
    logic [31:0] q_fifo[$];
    logic [31:0] m_words[$];
    logic [3:0]  m_nibs[$];
    int checks = 0;
    int errors = 0;
    bit ignore = 1'b1;
    int rd_cnt = 0;
    logic mon_prev_x = 1'b1;
    logic fifo_p;
    done_t mon_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CRC as the remainder of msg(x)*x^16 divided by x^16+x^12+x^5+1.
    function automatic logic [15:0] crc_line(input int line);
        bit d[$];
        logic [16:0] g;
        logic [15:0] r;
        g = 17'h11021;
        r = '0;
        foreach (m_nibs[i]) d.push_back(m_nibs[i][line]);
        repeat (16) d.push_back(1'b0);
        for (int i = 0; i < d.size() - 16; i++)
            if (d[i]) for (int j = 0; j < 17; j++) d[i+j] ^= g[16-j];
        for (int j = 0; j < 16; j++) r[15-j] = d[d.size()-16+j];
        return r;
    endfunction

    function automatic void build_nibs();
        m_nibs.delete();
        foreach (m_words[i])
            for (int k = 7; k >= 0; k--) m_nibs.push_back(m_words[i][k*4 +: 4]);
    endfunction

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!ignore) begin
                if (mon_prev_x && !bus.xfr_complete_o) rd_cnt = 0;
                if (bus.rd_o) rd_cnt++;
                if (bus.dat_oe_o) begin
                    if (q_dat.size() == 0) fail_now("dat_extra", "dat_oe_o high with no nibble expected");
                    else check("dat_o", 32'(bus.dat_o), 32'(q_dat.pop_front()));
                end
                if (bus.we_o) begin
                    if (q_we.size() == 0) fail_now("we_extra", "we_o pulse with no word expected");
                    else check("data_out_o", bus.data_out_o, q_we.pop_front());
                end
                if (!mon_prev_x && bus.xfr_complete_o) begin
                    if (q_done.size() == 0) fail_now("done_extra", "completion with no transfer expected");
                    else begin
                        mon_d = q_done.pop_front();
                        check("crc_ok_o", 32'(bus.crc_ok_o), 32'(mon_d.ok));
                        check("rd_count", rd_cnt, mon_d.rds);
                        check("dat_left", q_dat.size(), 0);
                        check("we_left", q_we.size(), 0);
                    end
                end
            end
            mon_prev_x = bus.xfr_complete_o;
        end
    end

    // TX FIFO model: a word is presented only in the cycle after rd_o.
    initial begin
        bus.data_in_i = '0;
        forever begin
            @(negedge clk);
            fifo_p = bus.rd_o;
            @(posedge clk);
            #1;
            if (fifo_p) begin
                if (q_fifo.size() > 0) bus.data_in_i = q_fifo.pop_front();
                else fail_now("fifo_underflow", "rd_o with TX FIFO empty");
            end else begin
                bus.data_in_i = $urandom();
            end
        end
    end

    task automatic wait_xfr(input string name);
        int n = 0;
        while (!bus.xfr_complete_o && n < 300) begin tick(); n++; end
        if (n >= 300) fail_now(name, "xfr_complete_o still low after 300 cycles");
        tick();
        tick();
    endtask

    task automatic flush();
        q_dat.delete(); q_we.delete(); q_done.delete(); q_fifo.delete();
    endtask

    task automatic do_write(input int blk, input logic [2:0] status, input int busy);
        logic [15:0] crc[4];
        int n = 0;
        build_nibs();
        for (int l = 0; l < 4; l++) crc[l] = crc_line(l);
        q_dat.push_back(4'hF);
        q_dat.push_back(4'h0);
        foreach (m_nibs[i]) q_dat.push_back(m_nibs[i]);
        for (int i = 0; i < 16; i++)
            q_dat.push_back({crc[3][15-i], crc[2][15-i], crc[1][15-i], crc[0][15-i]});
        q_dat.push_back(4'hF);
        foreach (m_words[i]) q_fifo.push_back(m_words[i]);
        q_done.push_back(done_t'{ok: (status == 3'b010), rds: m_words.size()});
        $display("write: blksize=%0d words=%0d status=%b busy=%0d", blk, m_words.size(), status, busy);
        bus.blksize_i = 12'(blk);
        bus.start_write_i = 1'b1;
        tick();
        bus.start_write_i = 1'b0;
        bus.blksize_i = 12'($urandom());
        while (!bus.dat_oe_o && n < 20) begin tick(); n++; end
        while (bus.dat_oe_o && n < 2000) begin tick(); n++; end
        if (n >= 2000) fail_now("wr_oe_timeout", "dat_oe_o never dropped");
        repeat (2) tick();
        bus.dat_i = 4'hE;
        tick();
        for (int b = 2; b >= 0; b--) begin
            bus.dat_i = {3'b111, status[b]};
            tick();
        end
        repeat (busy) begin
            bus.dat_i = 4'hE;
            tick();
        end
        bus.dat_i = 4'hF;
        wait_xfr("wr_done_timeout");
    endtask

    task automatic do_read(input int blk, input int flip_line, input int flip_bit);
        logic [15:0] crc[4];
        logic [3:0] v;
        build_nibs();
        for (int l = 0; l < 4; l++) crc[l] = crc_line(l);
        foreach (m_words[i]) q_we.push_back(m_words[i]);
        q_done.push_back(done_t'{ok: (flip_line < 0), rds: 0});
        $display("read: blksize=%0d words=%0d flip_line=%0d", blk, m_words.size(), flip_line);
        bus.blksize_i = 12'(blk);
        bus.start_read_i = 1'b1;
        tick();
        bus.start_read_i = 1'b0;
        bus.blksize_i = 12'($urandom());
        repeat ($urandom_range(0, 5)) tick();
        bus.dat_i = 4'h0;
        tick();
        foreach (m_nibs[i]) begin
            bus.dat_i = m_nibs[i];
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            v = {crc[3][15-i], crc[2][15-i], crc[1][15-i], crc[0][15-i]};
            if (flip_line >= 0 && i == flip_bit) v[flip_line] = ~v[flip_line];
            bus.dat_i = v;
            tick();
        end
        bus.dat_i = 4'hF;
        tick();
        wait_xfr("rd_done_timeout");
    endtask

    task automatic check_abort(input string tag);
        bus.start_write_i = 1'b1;
        bus.start_read_i = 1'b1;
        tick();
        bus.start_write_i = 1'b0;
        bus.start_read_i = 1'b0;
        check({tag, "_oe"}, 32'(bus.dat_oe_o), 32'd0);
        check({tag, "_xfr"}, 32'(bus.xfr_complete_o), 32'd1);
        check({tag, "_crc_ok"}, 32'(bus.crc_ok_o), 32'd0);
        flush();
        repeat (2) tick();
    endtask

    task automatic random_xfers();
        int blk;
        logic [2:0] st;
        for (int t = 0; t < 4; t++) begin
            blk = 4 * $urandom_range(1, 8);
            m_words.delete();
            repeat (blk / 4) m_words.push_back($urandom());
            st = ($urandom_range(0, 1) != 0) ? 3'b010 : 3'($urandom_range(0, 7));
            do_write(blk, st, $urandom_range(0, 6));
            blk = 4 * $urandom_range(1, 8);
            m_words.delete();
            repeat (blk / 4) m_words.push_back($urandom());
            if ($urandom_range(0, 1) != 0) do_read(blk, -1, 0);
            else do_read(blk, $urandom_range(0, 3), $urandom_range(0, 15));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running after time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start_write_i = 1'b0;
        bus.start_read_i = 1'b0;
        bus.blksize_i = 12'd4;
        bus.dat_i = 4'hF;
        #1;
        check("rst_oe", 32'(bus.dat_oe_o), 32'd0);
        check("rst_dat", 32'(bus.dat_o), 32'hF);
        check("rst_rd", 32'(bus.rd_o), 32'd0);
        check("rst_we", 32'(bus.we_o), 32'd0);
        check("rst_dout", bus.data_out_o, 32'd0);
        check("rst_xfr", 32'(bus.xfr_complete_o), 32'd1);
        check("rst_crc_ok", 32'(bus.crc_ok_o), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick();
        ignore = 1'b0;

        m_words = '{32'h12345678};
        do_write(4, 3'b010, 5);
        m_words = '{32'hA5A5A5A5, 32'h0F0F0F0F};
        do_write(8, 3'b101, 2);
        m_words = '{32'hDEADBEEF, 32'h01234567};
        do_read(8, -1, 0);
        do_read(8, 2, 7);

        $display("abort: mid write data");
        ignore = 1'b1;
        m_words = '{32'hCAFEF00D, 32'h13572468};
        foreach (m_words[i]) q_fifo.push_back(m_words[i]);
        bus.blksize_i = 12'd8;
        bus.start_write_i = 1'b1;
        tick();
        bus.start_write_i = 1'b0;
        repeat (5) tick();
        check("abort_wr_pre_oe", 32'(bus.dat_oe_o), 32'd1);
        check_abort("abort_wr");
        ignore = 1'b0;

        $display("abort: read wait");
        ignore = 1'b1;
        bus.start_read_i = 1'b1;
        tick();
        bus.start_read_i = 1'b0;
        repeat (3) tick();
        check("abort_rd_pre_xfr", 32'(bus.xfr_complete_o), 32'd0);
        check_abort("abort_rd");
        ignore = 1'b0;

        $display("reset: mid read");
        ignore = 1'b1;
        bus.blksize_i = 12'd8;
        bus.start_read_i = 1'b1;
        tick();
        bus.start_read_i = 1'b0;
        bus.dat_i = 4'h0;
        tick();
        repeat (5) begin bus.dat_i = 4'($urandom()); tick(); end
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_oe", 32'(bus.dat_oe_o), 32'd0);
        check("mrst_dat", 32'(bus.dat_o), 32'hF);
        check("mrst_we", 32'(bus.we_o), 32'd0);
        check("mrst_dout", bus.data_out_o, 32'd0);
        check("mrst_xfr", 32'(bus.xfr_complete_o), 32'd1);
        check("mrst_crc_ok", 32'(bus.crc_ok_o), 32'd0);
        bus.dat_i = 4'hF;
        flush();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        ignore = 1'b0;
        m_words = '{32'h89ABCDEF};
        do_write(4, 3'b010, 3);

        random_xfers();

        check("end_dat_q", q_dat.size(), 0);
        check("end_we_q", q_we.size(), 0);
        check("end_done_q", q_done.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_data_serializer.md
Name: sd_data_serializer

Overview:
- Serial data-path engine on the SD DAT[3:0] bus, directly downstream of sd_data_master.
- sd_data_master issues write/read pulses. This block moves one block of data between the FIFOs and the card: 4-bit bus, per-line CRC16.
- It returns completion (xfr_complete_o) and CRC status (crc_ok_o) to sd_data_master.
- No timeout logic; sd_data_master owns timeouts and aborts.

Parameters:
- BLKSIZE_W, 12, width of the block-size input in bytes.

Ports:
- sd_clk  input  1  SD clock; all logic on its rising edge.
- rst  input  1  asynchronous reset, active-low.
- start_write_i  input  1  one-cycle pulse (d_write_o from master): transmit a block.
- start_read_i  input  1  one-cycle pulse (d_read_o from master): receive a block.
- blksize_i  input  BLKSIZE_W  block size in bytes; nonzero multiple of 4; sampled at start.
- rd_o  output  1  TX FIFO read strobe; one-cycle pulse per word.
- data_in_i  input  32  TX FIFO word; valid the cycle after rd_o.
- we_o  output  1  RX FIFO write strobe; one-cycle pulse per word.
- data_out_o  output  32  RX word; valid while we_o=1.
- dat_oe_o  output  1  DAT output enable.
- dat_o  output  4  DAT drive value.
- dat_i  input  4  DAT sampled value.
- xfr_complete_o  output  1  1 when idle, 0 while a transfer is in progress.
- crc_ok_o  output  1  CRC result of the last transfer; valid when xfr_complete_o rises.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; dat_oe_o=0, dat_o=4'hF, rd_o=0, we_o=0, data_out_o=0, xfr_complete_o=1, crc_ok_o=0. Reset mid-transfer returns to IDLE immediately and drops dat_oe_o.
- Abort: start_write_i=1 and start_read_i=1 in the same cycle is an abort in any state.
  - Next cycle: IDLE, dat_oe_o=0, xfr_complete_o=1, crc_ok_o=0.
- Single starts outside IDLE are ignored.
- CRC: CRC16-CCITT, polynomial 0x1021, init 0x0000. One CRC per line, over that line's data bits only. Transmitted and compared MSB first.
- Nibble order: word bits [31:28] first, [3:0] last. Nibble count N = 2*blksize_i.
- Write flow: IDLE -> WR_FETCH -> WR_PRE -> WR_START -> WR_DATA -> WR_CRC -> WR_END -> WR_STAT -> WR_BUSY -> IDLE.
  - start_write_i in IDLE: xfr_complete_o=0 next cycle; rd_o pulses in WR_FETCH.
  - WR_PRE: dat_oe_o=1, dat_o=4'hF, 1 cycle.
  - WR_START: dat_o=4'h0, 1 cycle.
  - WR_DATA: N cycles, one nibble per cycle. rd_o pulses in the cycle the 8th nibble of a word goes out, but only if words remain, so the next word is ready with no bubble.
  - WR_CRC: 16 cycles, bit k of dat_o = CRC[line k] MSB first.
  - WR_END: dat_o=4'hF, 1 cycle.
  - Then dat_oe_o=0.
  - WR_STAT: wait for dat_i[0]=0 (status start bit), then capture the next 3 bits. crc_ok_o = (bits==3'b010).
  - WR_BUSY: wait while dat_i[0]=0. When dat_i[0]=1: IDLE, xfr_complete_o=1.
- Read flow: IDLE -> RD_WAIT -> RD_DATA -> RD_CRC -> RD_END -> IDLE.
  - dat_oe_o=0 throughout.
  - RD_WAIT: wait for dat_i[0]=0 (start bit); no internal limit.
  - RD_DATA: N cycles. Shift nibbles MSB-first into a 32-bit register. After every 8th nibble, we_o=1 for one cycle with data_out_o = assembled word.
  - RD_CRC: 16 cycles capturing the received CRC per line.
  - RD_END: 1 cycle, consumes the end bit. crc_ok_o = all four received CRCs equal the computed CRCs. Then IDLE, xfr_complete_o=1.
- crc_ok_o holds its value until the next start. It clears to 0 on any start or abort.
- Counters:
  - Nibble counter width BLKSIZE_W+1; no wrap within a block.
  - CRC bit counter 4 bits.
- blksize_i changes after start have no effect.

Test Plan:
- Write, blksize_i=4, data_in_i=0x12345678:
  - dat_o sequence F,0,1,2,3,4,5,6,7,8, then 16 CRC cycles matching the bench model, then F.
  - rd_o exactly 1 pulse. Card status 0,0,1,0 then DAT0 low 5 cycles -> crc_ok_o=1, xfr_complete_o rises.
- Write, blksize_i=8, words 0xA5A5A5A5 and 0x0F0F0F0F:
  - 2 rd_o pulses, 16 data nibbles contiguous with no gap.
  - Card status 0,1,0,1 -> crc_ok_o=0.
- Read, blksize_i=8: card drives start bit, nibbles of 0xDEADBEEF and 0x01234567, correct CRCs, end bit.
  - we_o pulses twice with those words; crc_ok_o=1.
- Read with one flipped CRC bit on line 2 -> crc_ok_o=0, FIFO words still written.
- Abort: start_write_i and start_read_i both =1 mid-WR_DATA (and again in RD_WAIT).
  - Next cycle dat_oe_o=0, xfr_complete_o=1, crc_ok_o=0.
- rst=0 mid-read: outputs take reset values asynchronously. A following write completes normally.
